// File: rtl/amp_envelope.sv
// Envelope detector for the receive chain: alpha-max-plus-beta-min magnitude
// estimate followed by peak-hold with exponential release.
module amp_envelope #(
    parameter int unsigned NBITS        = 16,
    parameter int unsigned HOLD_SAMPLES = 64,
    parameter int unsigned DECAY_SHIFT  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [NBITS-1:0] i_data,
    input  logic [NBITS-1:0] q_data,
    output logic [NBITS-1:0] amplitude,
    output logic             amp_valid
);

    localparam int unsigned HOLD_W = 16;
    localparam int unsigned SUM_W  = NBITS + 1;

    localparam logic [NBITS-1:0] MOST_NEG = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [NBITS-1:0] MOST_POS = {1'b0, {(NBITS-1){1'b1}}};
    localparam logic [NBITS-1:0] MAG_MAX  = {NBITS{1'b1}};

    // Absolute value with the most-negative code saturating to the largest positive
    function automatic logic [NBITS-1:0] sat_abs(input logic [NBITS-1:0] x);
        if (x == MOST_NEG)
            return MOST_POS;
        else if (x[NBITS-1])
            return (~x) + NBITS'(1);
        else
            return x;
    endfunction

    logic             v1, v2, v3;
    logic [NBITS-1:0] abs_i, abs_q;
    logic [NBITS-1:0] mx, mn;
    logic [NBITS-1:0] mag;
    logic [HOLD_W-1:0] hold_cnt;

    logic [NBITS-1:0]  abs_i_c, abs_q_c;
    logic [NBITS-1:0]  mx_c, mn_c;
    logic [SUM_W-1:0]  sum_c;
    logic [NBITS-1:0]  mag_c;
    logic [NBITS-1:0]  dec_c;
    logic [NBITS-1:0]  rel_c;
    logic [NBITS-1:0]  env_nxt_c;
    logic [HOLD_W-1:0] hold_nxt_c;

    // Magnitude datapath, one stage per edge
    always_comb begin
        abs_i_c = sat_abs(i_data);
        abs_q_c = sat_abs(q_data);

        mx_c = (abs_i >= abs_q) ? abs_i : abs_q;
        mn_c = (abs_i >= abs_q) ? abs_q : abs_i;

        sum_c = SUM_W'(mx) + SUM_W'(mn >> 2) + SUM_W'(mn >> 3);
        mag_c = sum_c[SUM_W-1] ? MAG_MAX : sum_c[NBITS-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            abs_i <= '0;
            abs_q <= '0;
            mx    <= '0;
            mn    <= '0;
            mag   <= '0;
        end else begin
            v1    <= valid;
            v2    <= v1;
            v3    <= v2;
            abs_i <= abs_i_c;
            abs_q <= abs_q_c;
            mx    <= mx_c;
            mn    <= mn_c;
            mag   <= mag_c;
        end
    end

    // Peak-hold / release; bubbles leave env and the hold counter untouched
    always_comb begin
        env_nxt_c  = amplitude;
        hold_nxt_c = hold_cnt;
        dec_c      = amplitude >> DECAY_SHIFT;
        if (dec_c == '0 && amplitude != '0)
            dec_c = NBITS'(1);
        rel_c = amplitude - dec_c;

        if (v3) begin
            if (mag >= amplitude) begin
                env_nxt_c  = mag;
                hold_nxt_c = HOLD_W'(HOLD_SAMPLES);
            end else if (hold_cnt != '0) begin
                hold_nxt_c = hold_cnt - HOLD_W'(1);
            end else begin
                env_nxt_c = (mag > rel_c) ? mag : rel_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amplitude <= '0;
            hold_cnt  <= '0;
            amp_valid <= 1'b0;
        end else begin
            amplitude <= env_nxt_c;
            hold_cnt  <= hold_nxt_c;
            amp_valid <= v3;
        end
    end

endmodule

// File: tb/tb_amp_envelope.sv
// Directed bench for amp_envelope: three instances with different hold settings
// share one stimulus stream; pulses are collected at the falling edge.
module tb_amp_envelope;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [15:0] i_data;
    logic [15:0] q_data;

    logic [15:0] amp_a, amp_b, amp_c;
    logic        av_a, av_b, av_c;

    int n_tests;
    int n_fail;
    int cyc;

    int qa_amp[$];
    int qa_cyc[$];
    int qb_amp[$];
    int qc_amp[$];
    int mags[$];
    int exp_env[$];

    amp_envelope #(.NBITS(16), .HOLD_SAMPLES(64), .DECAY_SHIFT(6)) u_a (
        .clk(clk), .rst(rst), .valid(valid), .i_data(i_data), .q_data(q_data),
        .amplitude(amp_a), .amp_valid(av_a)
    );

    amp_envelope #(.NBITS(16), .HOLD_SAMPLES(4), .DECAY_SHIFT(6)) u_b (
        .clk(clk), .rst(rst), .valid(valid), .i_data(i_data), .q_data(q_data),
        .amplitude(amp_b), .amp_valid(av_b)
    );

    amp_envelope #(.NBITS(16), .HOLD_SAMPLES(0), .DECAY_SHIFT(6)) u_c (
        .clk(clk), .rst(rst), .valid(valid), .i_data(i_data), .q_data(q_data),
        .amplitude(amp_c), .amp_valid(av_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (av_a === 1'b1) begin
            qa_amp.push_back(int'(amp_a));
            qa_cyc.push_back(cyc);
        end
        if (av_b === 1'b1) qb_amp.push_back(int'(amp_b));
        if (av_c === 1'b1) qc_amp.push_back(int'(amp_c));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_queues();
        qa_amp.delete();
        qa_cyc.delete();
        qb_amp.delete();
        qc_amp.delete();
    endtask

    task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] q);
        @(negedge clk);
        valid  = v;
        i_data = i;
        q_data = q;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 16'h0, 16'h0);
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_queues();
    endtask

    function automatic int mag_of(input logic [15:0] i, input logic [15:0] q);
        int si, sq, ai, aq, mx, mn, m;
        si = int'($signed(i));
        sq = int'($signed(q));
        ai = (si < 0) ? -si : si;
        aq = (sq < 0) ? -sq : sq;
        if (ai > 32767) ai = 32767;
        if (aq > 32767) aq = 32767;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
        m  = mx + (mn / 4) + (mn / 8);
        return (m > 65535) ? 65535 : m;
    endfunction

    // Reference envelope for a given hold length, DECAY_SHIFT = 6
    task automatic build_model(input int hold);
        int env, hc, dec, rel;
        env = 0;
        hc  = 0;
        exp_env.delete();
        foreach (mags[k]) begin
            if (mags[k] >= env) begin
                env = mags[k];
                hc  = hold;
            end else if (hc != 0) begin
                hc = hc - 1;
            end else begin
                dec = env / 64;
                if (dec == 0) dec = 1;
                rel = env - dec;
                env = (mags[k] > rel) ? mags[k] : rel;
            end
            exp_env.push_back(env);
        end
    endtask

    task automatic compare_queue(input string name, input int got[$]);
        int n;
        check($sformatf("%s_count", name), 32'(got.size()), 32'(exp_env.size()));
        n = (got.size() < exp_env.size()) ? got.size() : exp_env.size();
        for (int k = 0; k < n; k++)
            check($sformatf("%s_amp[%0d]", name, k), 32'(got[k]), 32'(exp_env[k]));
    endtask

    int drive_cyc;
    int t4_exp[8];
    int t5_exp[13];
    logic [15:0] ri, rq;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst     = 1'b0;
        valid   = 1'b0;
        i_data  = '0;
        q_data  = '0;

        // 1: asynchronous reset, no clock edge before the check
        #3 rst = 1'b1;
        #1;
        check("t1_async_amp", 32'(amp_a), 32'h0);
        check("t1_async_av", 32'(av_a), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("t1_idle_amp[%0d]", k), 32'(amp_a), 32'h0);
            check($sformatf("t1_idle_av[%0d]", k), 32'(av_a), 32'h0);
        end
        clear_queues();

        // 2: single sample latency and value
        drive(1'b1, 16'h1000, 16'h0000);
        drive_cyc = cyc;
        idle(7);
        check("t2_pulse_count", 32'(qa_amp.size()), 32'd1);
        if (qa_amp.size() >= 1) begin
            check("t2_amp", 32'(qa_amp[0]), 32'h1000);
            check("t2_latency", 32'(qa_cyc[0] - drive_cyc), 32'd4);
        end
        check("t2_amp_held", 32'(amp_a), 32'h1000);
        clear_queues();
        drive(1'b1, 16'h0BB8, 16'hF060);
        idle(6);
        check("t2b_count", 32'(qa_amp.size()), 32'd1);
        if (qa_amp.size() >= 1) check("t2b_amp", 32'(qa_amp[0]), 32'd5125);
        clear_queues();

        // 3: most-negative inputs saturate
        drive(1'b1, 16'h8000, 16'h8000);
        idle(6);
        check("t3_count", 32'(qa_amp.size()), 32'd1);
        if (qa_amp.size() >= 1) check("t3_amp", 32'(qa_amp[0]), 32'hAFFD);

        // 4: hold of 4 samples, then release
        t4_exp = '{4096, 4096, 4096, 4096, 4096, 4032, 3969, 3907};
        reset_all();
        drive(1'b1, 16'h1000, 16'h0000);
        for (int k = 0; k < 7; k++) drive(1'b1, 16'h0, 16'h0);
        idle(6);
        check("t4_count", 32'(qb_amp.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < qb_amp.size())
                check($sformatf("t4_amp[%0d]", k), 32'(qb_amp[k]), 32'(t4_exp[k]));

        // 5: minimum release step of 1 down to a sticky zero, then re-attack
        t5_exp = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0};
        reset_all();
        drive(1'b1, 16'd10, 16'h0000);
        for (int k = 0; k < 12; k++) drive(1'b1, 16'h0, 16'h0);
        idle(6);
        check("t5_count", 32'(qc_amp.size()), 32'd13);
        for (int k = 0; k < 13; k++)
            if (k < qc_amp.size())
                check($sformatf("t5_amp[%0d]", k), 32'(qc_amp[k]), 32'(t5_exp[k]));
        clear_queues();
        drive(1'b1, 16'd5, 16'h0000);
        idle(6);
        check("t5_reattack_count", 32'(qc_amp.size()), 32'd1);
        if (qc_amp.size() >= 1) check("t5_reattack", 32'(qc_amp[0]), 32'd5);

        // 6: reset mid-burst, then compare against a model of post-reset samples only
        reset_all();
        for (int k = 0; k < 12; k++) drive(1'b1, 16'($urandom), 16'($urandom));
        #2 rst = 1'b1;
        #1;
        check("t6_rst_amp_a", 32'(amp_a), 32'h0);
        check("t6_rst_av_a", 32'(av_a), 32'h0);
        check("t6_rst_amp_c", 32'(amp_c), 32'h0);
        valid = 1'b0;
        clear_queues();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mags.delete();
        for (int k = 0; k < 30; k++) begin
            ri = 16'($urandom);
            rq = 16'($urandom);
            if (k % 5 == 3) begin
                ri = ri >>> 6;
                rq = rq >>> 6;
            end
            drive(1'b1, ri, rq);
            mags.push_back(mag_of(ri, rq));
        end
        idle(6);
        build_model(64);
        compare_queue("t6_a", qa_amp);
        build_model(4);
        compare_queue("t6_b", qb_amp);
        build_model(0);
        compare_queue("t6_c", qc_amp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
